// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one async-FIFO write port among NUM_REQ
// requesters. A grant lasts for a burst of up to MAX_BURST words.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            write_clk,
  input  logic                            write_reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_write_en,
  output logic [DATA_WIDTH-1:0]           fifo_write_data,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                            busy
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  pick_found;
  logic [GW-1:0]         pick_id;

  // Mux the granted requester's valid/last/data.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // First valid requester at or after rr_ptr, wrapping explicitly at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_valid[GW'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = GW'(idx);
      end
    end
  end

  assign accept = (state_q == BURST) && sel_valid && !fifo_full;

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
          if (sel_last || (32'(burst_cnt_q) + 32'd1 == MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Outputs are decoded from the async-reset flops, so reset clears them at once.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == BURST) && (grant_id_q == GW'(i)) && !fifo_full;
    end
  end

  assign fifo_write_en   = accept;
  assign fifo_write_data = accept ? sel_data : '0;
  assign grant_id        = grant_id_q;
  assign busy            = (state_q == BURST);

endmodule
